// File: rtl/run_before_decoder.sv
// run_before_decoder: decodes the H.264 CAVLC run_before symbols of one block
// from a bit window, producing one run_before value per nonzero coefficient.
// Optional build macro RB_DEC_ERR_CHK_EN: enables detection of malformed codes
// (run_before larger than zeros left, or an all-zero 11-bit prefix), which
// aborts the block with err set. Without it err is tied low.
`timescale 1ns/1ps

module run_before_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  total_zero_cnt,
    input  logic [4:0]  coeff_cnt,
    input  logic [15:0] bs_window,
    input  logic        bs_valid,
    output logic        bs_shift,
    output logic [3:0]  bs_shift_len,
    output logic [4:0]  runbefore_list [0:15],
    output logic [4:0]  runbefore_cnt,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StDec, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  zero_left_q, zero_left_d;
    logic [4:0]  n_q, n_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  list_q [0:15];
    logic [4:0]  list_d [0:15];
    logic        done_q, done_d;
    logic        err_d;

    // Decoder results for the current window
    logic [4:0]  dec_run;
    logic [3:0]  dec_len;
    logic        dec_err;
    logic [3:0]  lz_cnt;
    logic        lz_found;
    logic [2:0]  zl_sel;
    logic [2:0]  top3;

    logic        terminal;
    logic        step;

    // Only the top 11 bits can ever be part of a code
    logic unused_window;
    assign unused_window = ^bs_window[4:0];

    assign top3     = bs_window[15:13];
    assign zl_sel   = (zero_left_q > 5'd7) ? 3'd7 : zero_left_q[2:0];
    assign terminal = (idx_q == 5'(n_q - 5'd1)) || (zero_left_q == 5'd0);
    // A symbol is actually consumed this cycle
    assign step     = (state_q == StDec) && (n_q != 5'd0) && !terminal && bs_valid && !dec_err;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_left_q <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                list_q[i] <= '0;
            end
        end else begin
            zero_left_q <= zero_left_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            for (int i = 0; i < 16; i++) begin
                list_q[i] <= list_d[i];
            end
        end
    end

`ifdef RB_DEC_ERR_CHK_EN
    logic err_q;

    // Sticky error flag, cleared by an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_err;
    assign unused_err = err_d;
    assign err = 1'b0;
`endif

    // run_before code table lookup, selected by min(zero_left, 7)
    always_comb begin
        dec_run  = '0;
        dec_len  = '0;
        dec_err  = 1'b0;
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (!lz_found) begin
                if (bs_window[15-i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz_cnt = 4'(lz_cnt + 4'd1);
                end
            end
        end
        case (zl_sel)
            3'd1: begin
                dec_len = 4'd1;
                dec_run = bs_window[15] ? 5'd0 : 5'd1;
            end
            3'd2: begin
                if (bs_window[15]) begin
                    dec_len = 4'd1;
                    dec_run = 5'd0;
                end else begin
                    dec_len = 4'd2;
                    dec_run = bs_window[14] ? 5'd1 : 5'd2;
                end
            end
            3'd3: begin
                dec_len = 4'd2;
                dec_run = 5'd3 - {3'd0, bs_window[15:14]};
            end
            3'd4: begin
                if (bs_window[15]) begin
                    dec_len = 4'd2;
                    dec_run = bs_window[14] ? 5'd0 : 5'd1;
                end else if (bs_window[14]) begin
                    dec_len = 4'd2;
                    dec_run = 5'd2;
                end else begin
                    dec_len = 4'd3;
                    dec_run = bs_window[13] ? 5'd3 : 5'd4;
                end
            end
            3'd5: begin
                if (bs_window[15]) begin
                    dec_len = 4'd2;
                    dec_run = bs_window[14] ? 5'd0 : 5'd1;
                end else begin
                    dec_len = 4'd3;
                    dec_run = 5'd5 - {3'd0, bs_window[14:13]};
                end
            end
            3'd6: begin
                if (bs_window[15:14] == 2'b11) begin
                    dec_len = 4'd2;
                    dec_run = 5'd0;
                end else begin
                    dec_len = 4'd3;
                    case (top3)
                        3'b000:  dec_run = 5'd1;
                        3'b001:  dec_run = 5'd2;
                        3'b011:  dec_run = 5'd3;
                        3'b010:  dec_run = 5'd4;
                        3'b101:  dec_run = 5'd5;
                        default: dec_run = 5'd6;
                    endcase
                end
            end
            default: begin
                if (top3 != 3'b000) begin
                    dec_len = 4'd3;
                    dec_run = 5'd7 - {2'd0, top3};
                end else if (lz_found) begin
                    // (k-1) zeros then a one -> run k+3
                    dec_len = 4'(lz_cnt + 4'd1);
                    dec_run = 5'(lz_cnt) + 5'd4;
                end else begin
                    // No valid code in 11 bits; consume the maximum
                    dec_len = 4'd11;
                    dec_run = 5'd15;
`ifdef RB_DEC_ERR_CHK_EN
                    dec_err = 1'b1;
`endif
                end
            end
        endcase
`ifdef RB_DEC_ERR_CHK_EN
        if (dec_run > zero_left_q) begin
            dec_err = 1'b1;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StDec;
            end
            StDec: begin
                if (n_q == 5'd0 || terminal) begin
                    state_d = StDone;
                end else if (bs_valid && dec_err) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state: block setup, list writes and zero_left tracking
    always_comb begin
        zero_left_d = zero_left_q;
        n_d         = n_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err;
        done_d      = (state_q == StDone);
        for (int i = 0; i < 16; i++) begin
            list_d[i] = list_q[i];
        end
        if (state_q == StIdle && start) begin
            zero_left_d = total_zero_cnt;
            n_d         = coeff_cnt;
            idx_d       = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            for (int i = 0; i < 16; i++) begin
                list_d[i] = '0;
            end
        end else if (state_q == StDec && n_q != 5'd0) begin
            if (terminal) begin
                list_d[idx_q[3:0]] = zero_left_q;
                cnt_d              = 5'(idx_q + 5'd1);
            end else if (bs_valid && dec_err) begin
                err_d = 1'b1;
            end else if (step) begin
                list_d[idx_q[3:0]] = dec_run;
                idx_d              = 5'(idx_q + 5'd1);
                zero_left_d        = (dec_run > zero_left_q) ? 5'd0 : 5'(zero_left_q - dec_run);
            end
        end
    end

    // Outputs
    always_comb begin
        bs_shift      = step;
        bs_shift_len  = step ? dec_len : 4'd0;
        busy          = (state_q != StIdle);
        done          = done_q;
        runbefore_cnt = cnt_q;
        for (int i = 0; i < 16; i++) begin
            runbefore_list[i] = list_q[i];
        end
    end

endmodule

// File: tb/tb_run_before_decoder.sv
// Directed bench for run_before_decoder: a bit-stream model feeds the window
// and shifts it by whatever the DUT consumes; results are checked against
// hand-decoded values.
`timescale 1ns/1ps

module tb_run_before_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  total_zero_cnt;
    logic [4:0]  coeff_cnt;
    logic [15:0] bs_window;
    logic        bs_valid;
    logic        bs_shift;
    logic [3:0]  bs_shift_len;
    logic [4:0]  runbefore_list [0:15];
    logic [4:0]  runbefore_cnt;
    logic        busy;
    logic        done;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          shift_lens[$];
    int          done_cyc;
    int          stall_shift;
    int          done_extra;
    logic [63:0] stream;

    always #5 clk = ~clk;

    run_before_decoder u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .total_zero_cnt (total_zero_cnt),
        .coeff_cnt      (coeff_cnt),
        .bs_window      (bs_window),
        .bs_valid       (bs_valid),
        .bs_shift       (bs_shift),
        .bs_shift_len   (bs_shift_len),
        .runbefore_list (runbefore_list),
        .runbefore_cnt  (runbefore_cnt),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs one block; the start edge is cycle 0, done_cyc is the edge after which done is seen
    task automatic run_block(input int tz, input int cf, input logic [63:0] bits,
                             input int stall_at, input int stall_len);
        logic       sh;
        logic [3:0] ln;
        shift_lens.delete();
        done_cyc    = -1;
        stall_shift = 0;
        done_extra  = 0;
        @(negedge clk);
        total_zero_cnt = 5'(tz);
        coeff_cnt      = 5'(cf);
        stream         = bits;
        bs_window      = stream[63:48];
        bs_valid       = 1'b1;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        bs_valid = !(stall_at == 0 && stall_len > 0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            sh = bs_shift;
            ln = bs_shift_len;
            if (sh) begin
                shift_lens.push_back(int'(ln));
                if (!bs_valid) stall_shift++;
            end
            @(posedge clk);
            #1;
            if (sh) stream = stream << ln;
            bs_window = stream[63:48];
            bs_valid  = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        bs_valid = 1'b1;
        @(posedge clk);
        #1;
        if (done) done_extra = 1;
    endtask

    task automatic check_block(input string tag, input int n_sh, input int exp_sh [4],
                               input int n_ls, input int exp_ls [4], input int exp_cnt,
                               input int exp_done);
        check_eq($sformatf("%s_nshift", tag), shift_lens.size(), n_sh);
        for (int i = 0; i < n_sh; i++) begin
            check_eq($sformatf("%s_shift%0d", tag, i),
                     (i < shift_lens.size()) ? shift_lens[i] : -1, exp_sh[i]);
        end
        for (int i = 0; i < n_ls; i++) begin
            check_eq($sformatf("%s_list%0d", tag, i), int'(runbefore_list[i]), exp_ls[i]);
        end
        check_eq($sformatf("%s_cnt", tag), int'(runbefore_cnt), exp_cnt);
        check_eq($sformatf("%s_done_cyc", tag), done_cyc, exp_done);
        check_eq($sformatf("%s_done_width", tag), done_extra, 0);
        check_eq($sformatf("%s_busy_after", tag), int'(busy), 0);
    endtask

    initial begin
        int seen_done;
        rst            = 1'b0;
        start          = 1'b0;
        total_zero_cnt = 5'd0;
        coeff_cnt      = 5'd0;
        bs_window      = 16'hFFFF;
        bs_valid       = 1'b1;
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_err", int'(err), 0);
        check_eq("rst_shift", int'(bs_shift), 0);
        check_eq("rst_shift_len", int'(bs_shift_len), 0);
        check_eq("rst_cnt", int'(runbefore_cnt), 0);
        check_eq("rst_list0", int'(runbefore_list[0]), 0);
        @(negedge clk);
        rst = 1'b1;

        // tz=3, n=4, bits 10 1 01 -> runs 1,0,1 and last entry takes the remaining 1
        run_block(3, 4, 64'hA800_0000_0000_0000, -1, 0);
        check_block("A", 3, '{2, 1, 2, 0}, 4, '{1, 0, 1, 1}, 4, 5);
        check_eq("A_err", int'(err), 0);

`ifdef RB_DEC_ERR_CHK_EN
        // run 11 exceeds zero_left 9: aborted with err, nothing consumed
        run_block(9, 2, 64'h0100_0000_0000_0000, -1, 0);
        check_block("B", 0, '{0, 0, 0, 0}, 2, '{0, 0, 0, 0}, 0, 2);
        check_eq("B_err", int'(err), 1);
`else
        // run 11 consumed (8 bits), zero_left saturates to 0, last entry 0
        run_block(9, 2, 64'h0100_0000_0000_0000, -1, 0);
        check_block("B", 1, '{8, 0, 0, 0}, 2, '{11, 0, 0, 0}, 2, 3);
        check_eq("B_err", int'(err), 0);
`endif

        // 00001 -> run 8, remaining 2 goes to the last entry
        run_block(10, 2, 64'h0800_0000_0000_0000, -1, 0);
        check_block("C", 1, '{5, 0, 0, 0}, 2, '{8, 2, 0, 0}, 2, 3);

        // zero total zeros: immediate terminal, stale list[1] must be cleared
        run_block(0, 5, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
        check_block("D", 0, '{0, 0, 0, 0}, 2, '{0, 0, 0, 0}, 1, 2);

        // no coefficients
        run_block(4, 0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0);
        check_block("E", 0, '{0, 0, 0, 0}, 1, '{0, 0, 0, 0}, 0, 2);

        // zl 7 table 101 -> 2, then zl 5 table 011 -> 2, last gets 3
        run_block(7, 3, 64'hAC00_0000_0000_0000, -1, 0);
        check_block("F", 2, '{3, 3, 0, 0}, 3, '{2, 2, 3, 0}, 3, 4);

        // zl 6 table 101 -> 5, then zl 1 table 0 -> 1, last gets 0
        run_block(6, 3, 64'hA000_0000_0000_0000, -1, 0);
        check_block("G", 2, '{3, 1, 0, 0}, 3, '{5, 1, 0, 0}, 3, 4);

        // zl 4 table 001 -> 3, last gets 1
        run_block(4, 2, 64'h2000_0000_0000_0000, -1, 0);
        check_block("H", 1, '{3, 0, 0, 0}, 2, '{3, 1, 0, 0}, 2, 3);

        // block A with bs_valid low for 3 cycles mid-block -> done 3 cycles later
        run_block(3, 4, 64'hA800_0000_0000_0000, 1, 3);
        check_block("S", 3, '{2, 1, 2, 0}, 4, '{1, 0, 1, 1}, 4, 8);
        check_eq("S_stall_shift", stall_shift, 0);

        // reset in the middle of DEC
        @(negedge clk);
        total_zero_cnt = 5'd3;
        coeff_cnt      = 5'd4;
        stream         = 64'hA800_0000_0000_0000;
        bs_window      = stream[63:48];
        bs_valid       = 1'b1;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("R_busy", int'(busy), 0);
        check_eq("R_shift", int'(bs_shift), 0);
        check_eq("R_shift_len", int'(bs_shift_len), 0);
        check_eq("R_cnt", int'(runbefore_cnt), 0);
        check_eq("R_list0", int'(runbefore_list[0]), 0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check_eq("R_no_done", seen_done, 0);
        run_block(10, 2, 64'h0800_0000_0000_0000, -1, 0);
        check_block("RC", 1, '{5, 0, 0, 0}, 2, '{8, 2, 0, 0}, 2, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/run_before_decoder.md
RUN_BEFORE_DECODER -- requirements
Module: run_before_decoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be: clk in 1 (clock); rst in 1 (asynchronous, active-low reset).
REQ-003 Further ports SHALL be: start in 1 (begin block, single-cycle pulse); total_zero_cnt in 5 (total_zeros of block, 0..15); coeff_cnt in 5 (nonzero coefficient count, 0..16).
REQ-004 Bitstream ports SHALL be: bs_window in 16 (next unread bits, MSB = oldest); bs_valid in 1 (window holds >=11 valid bits); bs_shift out 1 (consume pulse); bs_shift_len out 4 (bits consumed, 1..11).
REQ-005 Result ports SHALL be: runbefore_list out 5x[0:15] (run_before per coefficient, index 0 = highest-frequency coefficient); runbefore_cnt out 5 (entries written); busy out 1; done out 1 (single-cycle pulse); err out 1 (sticky until next start).

Function
REQ-006 The FSM SHALL have states IDLE, DEC, DONE; start SHALL be accepted only in IDLE and SHALL be ignored otherwise.
REQ-007 On start, the block SHALL latch zero_left=total_zero_cnt and n=coeff_cnt, set idx=0, clear all list entries, clear runbefore_cnt and err, and go to DEC.
REQ-008 If n==0, DEC SHALL go directly to DONE with runbefore_cnt=0 and no bits consumed.
REQ-009 Terminal condition in DEC, (idx==n-1) or (zero_left==0): write list[idx]=zero_left, set runbefore_cnt=idx+1, consume no bits, go to DONE.
REQ-010 Otherwise, in DEC with bs_valid=1, the block SHALL decode one run_before from bs_window using the H.264 run_before table indexed by min(zero_left,7).
REQ-011 In that same cycle the block SHALL assert bs_shift with bs_shift_len equal to the code length, write list[idx], set idx+=1, and set zero_left-=run_before.
REQ-012 In DEC with bs_valid=0, the block SHALL hold all state and keep bs_shift=0.
REQ-013 Table for zero_left 1: 1->0, 0->1.
REQ-014 Table for zero_left 2: 1->0, 01->1, 00->2.
REQ-015 Table for zero_left 3: 11->0, 10->1, 01->2, 00->3.
REQ-016 Table for zero_left 4: 11->0, 10->1, 01->2, 001->3, 000->4.
REQ-017 Table for zero_left 5: 11->0, 10->1, 011->2, 010->3, 001->4, 000->5.
REQ-018 Table for zero_left 6: 11->0, 000->1, 001->2, 011->3, 010->4, 101->5, 100->6.
REQ-019 Table for zero_left >6: 111..001 -> 0..6; for k=4..11, (k-1) zeros then a 1 -> run k+3 (7..14).
REQ-020 bs_shift_len SHALL never exceed 11; bs_shift SHALL be combinational from state and bs_window.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-022 runbefore_list and runbefore_cnt SHALL hold their values until the next accepted start.
REQ-023 Latency: with bs_valid held high and m coded entries, done SHALL rise m+2 cycles after the start edge.
REQ-024 busy SHALL be 1 in DEC and DONE, and 0 in IDLE.

Reset
REQ-025 When rst=0, asynchronously: state=IDLE; idx, zero_left, runbefore_cnt and all list entries =0; done, err, busy, bs_shift =0; bs_shift_len=0.
REQ-026 If reset is asserted mid-block, the block SHALL abandon it with no done pulse; the first start after reset release SHALL begin a clean block.

Configuration
REQ-027 With RB_DEC_ERR_CHK_EN defined, the following SHALL be an error: a decoded run_before > zero_left, or 11 leading zeros when zero_left > 6.
REQ-028 On such an error, the block SHALL set err=1, consume no bits, write nothing, and go to DONE (done still pulses).
REQ-029 Without RB_DEC_ERR_CHK_EN, err SHALL be tied to 0, no checks SHALL be performed, and zero_left SHALL saturate at 0.

Verification
REQ-030 total_zero=3, coeff=4, window=16'b1010_1xxx_xxxx_xxxx, bs_valid=1 -> shifts of 2, 1, 2; list[0..3]={1,0,1,1}; runbefore_cnt=4; done 5 cycles after start.
REQ-031 total_zero=9, coeff=2, window=16'b0000_0001_xxxx_xxxx -> one shift of 8 (run 11 exceeds 9); with RB_DEC_ERR_CHK_EN: err=1, cnt=0, no shift.
REQ-032 total_zero=10, coeff=2, window=16'b0000_1xxx_xxxx_xxxx -> shift 5, list[0]=8, list[1]=2, cnt=2.
REQ-033 total_zero=0, coeff=5 -> no shift, list[0]=0, cnt=1, done 2 cycles after start; coeff=0 -> cnt=0, no shift.
REQ-034 Hold bs_valid=0 for 3 cycles mid-block -> no shift and state held; then resumes and done is delayed by exactly 3 cycles.
REQ-035 Assert rst=0 during DEC -> all outputs 0 immediately, no done; a subsequent start decodes correctly.
